dcache_refill_ctrl: RTL

//  Miss handler on the memory side of the 4-way data cache. Accepts a miss, reads the missing
//  32-bit word from main memory and installs it via the cache fetch port. Captures the evicted
//  tag/word and writes the word back to memory when the evicted way is both valid and dirty.

---
 rtl/dcache_refill_if.sv | 34 +++
 rtl/dcache_refill_ctrl.sv | 77 +++++++
 2 files changed

// File: rtl/dcache_refill_if.sv
// dcache_refill_if: miss, cache-fetch, victim and main-memory signals of the data-cache refill controller.
interface dcache_refill_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
);
    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              cache_fetch;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wdata;
    logic [15:0]       evict_tag;
    logic [DATA_W-1:0] evict_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  miss_valid, miss_addr, evict_tag, evict_data, mem_ack, mem_rdata,
        output busy, done, err, cache_fetch, cache_addr, cache_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output miss_valid, miss_addr, evict_tag, evict_data, mem_ack, mem_rdata,
        input  busy, done, err, cache_fetch, cache_addr, cache_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// dcache_refill_ctrl: reads a missing word from memory, installs it in the cache and
// writes back a valid dirty victim, with a per-transaction memory timeout.
module dcache_refill_ctrl #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 32,
    parameter int EVICT_LAT = 2,
    parameter int MEM_TMO   = 255
) (
    input logic           CLK,
    input logic           RST_N,
    dcache_refill_if.master bus
);
    localparam int CW = $clog2(MEM_TMO + EVICT_LAT + 1);

    typedef enum logic [2:0] {IDLE, RD, FILL, EVWAIT, WB, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] addr_q, wb_addr_q;
    logic [DATA_W-1:0] rdata_q, ev_data_q;
    logic              err_q, tmo, ev_last, unused_bits;

    // one counter serves both the memory timeout and the victim-latency wait; it restarts on every state change
    assign ev_last     = state == EVWAIT && cnt == CW'(EVICT_LAT - 1);
    assign tmo         = (state == RD || state == WB) && !bus.mem_ack && cnt == CW'(MEM_TMO - 1);
    assign unused_bits = ^{bus.evict_tag[15:14], bus.evict_tag[11:10]};

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.miss_valid ? RD : IDLE;
            RD:      state_n = bus.mem_ack ? FILL : tmo ? DONE : RD;
            FILL:    state_n = EVWAIT;
            EVWAIT:  state_n = !ev_last ? EVWAIT : (bus.evict_tag[13] & bus.evict_tag[12]) ? WB : DONE;
            WB:      state_n = (bus.mem_ack || tmo) ? DONE : WB;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wb_addr_q <= '0;
            rdata_q   <= '0;
            ev_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
            if (state == IDLE && bus.miss_valid) begin
                addr_q <= bus.miss_addr & ~ADDR_W'(3);
                err_q  <= 1'b0;
            end
            if (state == RD && bus.mem_ack)
                rdata_q <= bus.mem_rdata;
            if (ev_last) begin
                ev_data_q <= bus.evict_data;
                wb_addr_q <= ADDR_W'({bus.evict_tag[9:0], addr_q[9:2], 2'b00});
            end
            if (tmo)
                err_q <= 1'b1;
        end
    end

    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.err         = state == DONE && err_q;
    assign bus.cache_fetch = state == FILL;
    assign bus.cache_addr  = addr_q;
    assign bus.cache_wdata = rdata_q;
    assign bus.mem_req     = state == RD || state == WB;
    assign bus.mem_we      = state == WB;
    assign bus.mem_addr    = state == WB ? wb_addr_q : addr_q;
    assign bus.mem_wdata   = ev_data_q;
endmodule
